sdc_wb_arbiter: RTL and testbench

SDC_WB_ARBITER -- requirements
Module: sdc_wb_arbiter

---
 rtl/sdc_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_sdc_wb_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_wb_arbiter.sv
// Two-master classic Wishbone arbiter with round-robin grant and a per-strobe
// slave wait timeout that aborts the cycle and drains the stalled master.
module sdc_wb_arbiter #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    output logic            m0_err,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_dat_i,
    output logic            timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;   // last granted master; also the one aborted/drained
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req0, req1, sel1;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = '0;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_o   = '0;
        s_sel     = '0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m0_dat_o  = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m1_dat_o  = '0;
        timeout_o = 1'b0;
        req0      = m0_cyc & m0_stb;
        req1      = m1_cyc & m1_stb;
        sel1      = (state_q == GNT1);

        case (state_q)
            IDLE: begin
                // Contention goes to whichever master was not granted last.
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                s_cyc    = sel1 ? m1_cyc   : m0_cyc;
                s_stb    = sel1 ? m1_stb   : m0_stb;
                s_we     = sel1 ? m1_we    : m0_we;
                s_adr    = sel1 ? m1_adr   : m0_adr;
                s_dat_o  = sel1 ? m1_dat_i : m0_dat_i;
                s_sel    = sel1 ? m1_sel   : m0_sel;
                m0_ack   = !sel1 & s_ack;
                m1_ack   = sel1 & s_ack;
                m0_dat_o = sel1 ? '0 : s_dat_i;
                m1_dat_o = sel1 ? s_dat_i : '0;
                // An ack on the last allowed wait cycle still completes normally.
                if (!s_cyc) begin
                    state_d = IDLE;
                end else if (s_stb && !s_ack) begin
                    if (cnt_q == TO_LAST) state_d = ABORT;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
            end
            ABORT: begin
                m0_err    = !last_q;
                m1_err    = last_q;
                timeout_o = 1'b1;
                state_d   = DRAIN;
            end
            DRAIN: begin
                if (!(last_q ? m1_cyc : m0_cyc)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sdc_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random masters/slave, all
// compared against a transaction-level reference model of the arbiter.
module tb_sdc_wb_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstn;
    logic c0, s0, w0, c1, s1, w1, sack;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, sdat;
    logic [3:0] sl0, sl1;
    logic ack0, err0, ack1, err1, scyc, sstb, swe, tout;
    logic [DW-1:0] dat0, dat1, sdato;
    logic [AW-1:0] sadr;
    logic [3:0] ssel;

    int nchk = 0, nfail = 0;
    // reference model: granted master (-1 none), abort/drain phase, wait length
    int g, ab, dr, wt, last;
    int n_scyc, n_to, n_err0, n_err1, n_ack0, n_ack1;
    logic o_scyc, o_ack0, o_ack1, o_to;
    logic [AW-1:0] o_adr;
    logic [DW-1:0] o_dat0;
    bit stall = 0;

    always #5 clk = ~clk;

    sdc_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .aclk(clk), .aresetn(rstn),
        .m0_cyc(c0), .m0_stb(s0), .m0_we(w0), .m0_adr(a0), .m0_dat_i(d0), .m0_sel(sl0),
        .m0_ack(ack0), .m0_err(err0), .m0_dat_o(dat0),
        .m1_cyc(c1), .m1_stb(s1), .m1_we(w1), .m1_adr(a1), .m1_dat_i(d1), .m1_sel(sl1),
        .m1_ack(ack1), .m1_err(err1), .m1_dat_o(dat1),
        .s_cyc(scyc), .s_stb(sstb), .s_we(swe), .s_adr(sadr), .s_dat_o(sdato), .s_sel(ssel),
        .s_ack(sack), .s_dat_i(sdat), .timeout_o(tout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic mcyc(input int n);
        return n == 1 ? c1 : c0;
    endfunction

    task automatic model_edge();
        logic r0, r1;
        if (!rstn) begin
            g = -1; ab = 0; dr = 0; wt = 0; last = 1;
        end else if (ab != 0) begin
            ab = 0; dr = 1;
        end else if (dr != 0) begin
            if (!mcyc(last)) dr = 0;
        end else if (g < 0) begin
            r0 = c0 & s0;
            r1 = c1 & s1;
            if (r0 && r1)  g = 1 - last;
            else if (r0)   g = 0;
            else if (r1)   g = 1;
            if (g >= 0) begin last = g; wt = 0; end
        end else if (!mcyc(g)) begin
            g = -1;
        end else if ((g == 1 ? s1 : s0) && !sack) begin
            wt++;
            if (wt == TO) begin g = -1; ab = 1; wt = 0; end
        end else begin
            wt = 0;
        end
    endtask

    // One clock: inputs were applied at the falling edge; check, then advance.
    task automatic step(input bit en);
        logic e_cyc, e_stb, e_we, e_a0, e_a1, e_e0, e_e1, e_to;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_do, e_d0, e_d1;
        logic [3:0] e_sel;
        #1;
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_do = '0; e_sel = '0;
        e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0; e_to = 0; e_d0 = '0; e_d1 = '0;
        if (g == 0) begin
            e_cyc = c0; e_stb = s0; e_we = w0; e_adr = a0; e_do = d0; e_sel = sl0;
            e_a0 = sack; e_d0 = sdat;
        end else if (g == 1) begin
            e_cyc = c1; e_stb = s1; e_we = w1; e_adr = a1; e_do = d1; e_sel = sl1;
            e_a1 = sack; e_d1 = sdat;
        end
        if (ab != 0) begin
            e_to = 1;
            if (last == 1) e_e1 = 1; else e_e0 = 1;
        end
        if (en) begin
            chk("s_cyc", scyc, e_cyc);   chk("s_stb", sstb, e_stb);
            chk("s_we", swe, e_we);      chk("s_adr", sadr, e_adr);
            chk("s_dat_o", sdato, e_do); chk("s_sel", ssel, e_sel);
            chk("m0_ack", ack0, e_a0);   chk("m0_err", err0, e_e0);
            chk("m0_dat_o", dat0, e_d0); chk("m1_ack", ack1, e_a1);
            chk("m1_err", err1, e_e1);   chk("m1_dat_o", dat1, e_d1);
            chk("timeout_o", tout, e_to);
        end
        n_scyc += int'(scyc); n_to += int'(tout); n_err0 += int'(err0);
        n_err1 += int'(err1); n_ack0 += int'(ack0); n_ack1 += int'(ack1);
        o_scyc = scyc; o_ack0 = ack0; o_ack1 = ack1; o_to = tout; o_adr = sadr; o_dat0 = dat0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clr();
        n_scyc = 0; n_to = 0; n_err0 = 0; n_err1 = 0; n_ack0 = 0; n_ack1 = 0;
    endtask

    task automatic idle_all();
        c0 = 0; s0 = 0; c1 = 0; s1 = 0; sack = 0;
    endtask

    initial begin
        rstn = 0; idle_all();
        w0 = 0; w1 = 1; a0 = '0; a1 = '0; d0 = 32'h1111_0000; d1 = 32'h2222_0000;
        sl0 = 4'hF; sl1 = 4'h3; sdat = '0;
        g = -1; ab = 0; dr = 0; wt = 0; last = 1;
        @(negedge clk);
        step(0);
        step(1);
        chk("rst_scyc", o_scyc, 0);
        rstn = 1;

        // single read from m0, slave answers on the third granted cycle
        c0 = 1; s0 = 1; a0 = 'h10;
        step(1);
        step(1); step(1);
        clr(); sack = 1; sdat = 32'hDEADBEEF;
        step(1);
        chk("r029_ack", o_ack0, 1); chk("r029_dat", o_dat0, 32'hDEADBEEF);
        chk("r029_ack1", o_ack1, 0); chk("r029_once", n_ack0, 1);
        c0 = 0; s0 = 0; sack = 0;
        step(1);

        // simultaneous requests from reset, then round-robin
        rstn = 0; step(1); rstn = 1;
        c0 = 1; s0 = 1; a0 = 'hA0; c1 = 1; s1 = 1; a1 = 'hB1;
        step(1);
        sack = 1; step(1);
        chk("r030_first", o_adr, 'hA0);
        c0 = 0; s0 = 0; sack = 0; step(1);
        c0 = 1; s0 = 1;
        step(1);
        chk("r030_gap", o_scyc, 0);
        sack = 1; step(1);
        chk("r030_second", o_adr, 'hB1);
        idle_all(); step(1); step(1);

        // m1 never acked: abort after TO strobe cycles, then drain
        c1 = 1; s1 = 1;
        step(1);
        clr();
        for (int i = 0; i < 14; i++) step(1);
        chk("r031_cyc_cycles", n_scyc, TO); chk("r031_to", n_to, 1);
        chk("r031_err1", n_err1, 1);        chk("r031_ack1", n_ack1, 0);
        chk("r031_drain", o_scyc, 0);
        idle_all(); step(1); step(1);

        // ack on the final allowed wait cycle completes normally
        c0 = 1; s0 = 1;
        step(1);
        clr();
        for (int i = 0; i < TO - 1; i++) step(1);
        sack = 1; step(1);
        chk("r034_ack", o_ack0, 1); chk("r034_to", n_to, 0); chk("r034_err", n_err0, 0);
        idle_all(); step(1); step(1);

        // m0 keeps its cycle for four strobes while m1 waits
        c0 = 1; s0 = 1; a0 = '0;
        step(1);
        c1 = 1; s1 = 1; a1 = 'h3FF; sack = 1;
        for (int i = 0; i < 4; i++) begin
            a0 = AW'(i);
            step(1);
            chk("r032_adr", o_adr, i); chk("r032_ack0", o_ack0, 1); chk("r032_ack1", o_ack1, 0);
        end
        c0 = 0; s0 = 0; sack = 0; step(1);
        step(1);
        sack = 0; step(1);
        chk("r032_m1_gnt", o_adr, 'h3FF);

        // reset while m1 is granted with a pending strobe
        rstn = 0; step(1);
        rstn = 1; sack = 1; c0 = 1; s0 = 1; a0 = 'h55;
        step(1);
        chk("r033_scyc", o_scyc, 0); chk("r033_ack1", o_ack1, 0);
        sack = 0; step(1);
        chk("r033_prio", o_adr, 'h55);
        idle_all(); step(1); step(1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 99) != 0);
            if (c0) begin
                if ($urandom_range(0, 15) == 0) begin c0 = 0; s0 = 0; end
                else s0 = ($urandom_range(0, 7) != 0);
            end else if ($urandom_range(0, 3) == 0) begin c0 = 1; s0 = 1; end
            if (c1) begin
                if ($urandom_range(0, 15) == 0) begin c1 = 0; s1 = 0; end
                else s1 = ($urandom_range(0, 7) != 0);
            end else if ($urandom_range(0, 3) == 0) begin c1 = 1; s1 = 1; end
            w0 = 1'($urandom); w1 = 1'($urandom);
            a0 = AW'($urandom); a1 = AW'($urandom);
            d0 = $urandom; d1 = $urandom; sdat = $urandom;
            sl0 = 4'($urandom); sl1 = 4'($urandom);
            if ($urandom_range(0, 39) == 0) stall = !stall;
            sack = stall ? 1'b0 : ($urandom_range(0, 2) == 0);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
